level_sequencer: RTL and testbench

//  Game-flow FSM that sequences the step/tile map block. It loads levels, opens the gate

---
 rtl/level_sequencer_if.sv | 28 ++
 rtl/level_sequencer.sv | 152 +++++++++++++++
 tb/tb_level_sequencer.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/level_sequencer_if.sv
// Event and HUD/map signals between Bumpy's tile logic and the level sequencer.
// master drives the tile events; slave is the sequencer that answers with level/gate/lives.
interface level_sequencer_if;
    logic       startOfFrame;
    logic       start_key;
    logic       land_regu;
    logic       hit_spike;
    logic       fell_out;
    logic       on_gate_tile;
    logic [2:0] lvl;
    logic       next_lvl;
    logic       gate;
    logic       respawn;
    logic [1:0] lives;
    logic       game_over;
    logic       win;
    logic [2:0] state_dbg;

    modport master (
        output startOfFrame, start_key, land_regu, hit_spike, fell_out, on_gate_tile,
        input  lvl, next_lvl, gate, respawn, lives, game_over, win, state_dbg
    );

    modport slave (
        input  startOfFrame, start_key, land_regu, hit_spike, fell_out, on_gate_tile,
        output lvl, next_lvl, gate, respawn, lives, game_over, win, state_dbg
    );
endinterface

// File: rtl/level_sequencer.sv
// Game-flow FSM for the tile map: loads levels, opens the gate after enough landings,
// and handles deaths, level completion, win and game over. All outputs are registered.
//  state      | meaning
//  IDLE(0)    | waiting for start_key
//  LOAD(1)    | one-cycle map reload, next_lvl/respawn high
//  PLAY(2)    | counting REGU landings, gate closed
//  GATE_OPEN  | gate shown, waiting for Bumpy to enter it
//  LVL_DONE   | level cleared, holding DONE_FRAMES frames
//  DYING      | death animation, holding DEATH_FRAMES frames
//  GAME_OVER  | no lives left, waits for start_key
//  WIN(7)     | last level cleared, waits for start_key
module level_sequencer #(
    parameter int NUM_LEVELS       = 2,
    parameter int LANDINGS_TO_OPEN = 5,
    parameter int START_LIVES      = 3,
    parameter int DONE_FRAMES      = 60,
    parameter int DEATH_FRAMES     = 45
) (
    input  logic               clk,
    input  logic               resetN,
    level_sequencer_if.slave   bus
);

    localparam int FRAME_MAX = (DONE_FRAMES > DEATH_FRAMES) ? DONE_FRAMES : DEATH_FRAMES;
    localparam int FW        = $clog2(FRAME_MAX + 1);
    localparam int LW        = $clog2(LANDINGS_TO_OPEN + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_PLAY      = 3'd2,
        S_GATE_OPEN = 3'd3,
        S_LVL_DONE  = 3'd4,
        S_DYING     = 3'd5,
        S_GAME_OVER = 3'd6,
        S_WIN       = 3'd7
    } state_t;

    state_t          r_state;
    logic [2:0]      r_lvl;
    logic            r_next_lvl;
    logic            r_gate;
    logic            r_respawn;
    logic [1:0]      r_lives;
    logic            r_game_over;
    logic            r_win;
    logic [LW-1:0]   r_land_cnt;
    logic [FW-1:0]   r_frame_cnt;

    logic            w_death;
    logic [FW-1:0]   w_frame_nxt;

    // A death needs a life to spend, so lives can never wrap below zero.
    assign w_death     = (bus.hit_spike | bus.fell_out) & (r_lives != 2'd0);
    assign w_frame_nxt = r_frame_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_state     <= S_IDLE;
            r_lvl       <= 3'd0;
            r_next_lvl  <= 1'b0;
            r_gate      <= 1'b0;
            r_respawn   <= 1'b0;
            r_lives     <= 2'(START_LIVES);
            r_game_over <= 1'b0;
            r_win       <= 1'b0;
            r_land_cnt  <= '0;
            r_frame_cnt <= '0;
        end else begin
            r_next_lvl <= 1'b0;
            r_respawn  <= 1'b0;
            case (r_state)
                S_IDLE, S_GAME_OVER, S_WIN: begin
                    if (bus.start_key) begin
                        r_state     <= S_LOAD;
                        r_lvl       <= 3'd0;
                        r_lives     <= 2'(START_LIVES);
                        r_gate      <= 1'b0;
                        r_game_over <= 1'b0;
                        r_win       <= 1'b0;
                        r_next_lvl  <= 1'b1;
                        r_respawn   <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_state    <= S_PLAY;
                    r_land_cnt <= '0;
                    r_gate     <= 1'b0;
                end
                S_PLAY, S_GATE_OPEN: begin
                    if (w_death) begin
                        r_state     <= S_DYING;
                        r_frame_cnt <= '0;
                        r_lives     <= r_lives - 2'd1;
                    end else if (r_state == S_PLAY) begin
                        if (bus.land_regu && (r_land_cnt != LW'(LANDINGS_TO_OPEN))) begin
                            r_land_cnt <= r_land_cnt + 1'b1;
                            if (r_land_cnt == LW'(LANDINGS_TO_OPEN - 1)) begin
                                r_state <= S_GATE_OPEN;
                                r_gate  <= 1'b1;
                            end
                        end
                    end else if (bus.on_gate_tile) begin
                        r_state     <= S_LVL_DONE;
                        r_frame_cnt <= '0;
                    end
                end
                S_LVL_DONE: begin
                    if (bus.startOfFrame) begin
                        r_frame_cnt <= w_frame_nxt;
                        if (w_frame_nxt == FW'(DONE_FRAMES)) begin
                            if (r_lvl == 3'(NUM_LEVELS - 1)) begin
                                r_state <= S_WIN;
                                r_win   <= 1'b1;
                            end else begin
                                r_state    <= S_LOAD;
                                r_lvl      <= r_lvl + 3'd1;
                                r_next_lvl <= 1'b1;
                                r_respawn  <= 1'b1;
                            end
                        end
                    end
                end
                S_DYING: begin
                    if (bus.startOfFrame) begin
                        r_frame_cnt <= w_frame_nxt;
                        if (w_frame_nxt == FW'(DEATH_FRAMES)) begin
                            if (r_lives == 2'd0) begin
                                r_state     <= S_GAME_OVER;
                                r_game_over <= 1'b1;
                            end else begin
                                r_state   <= r_gate ? S_GATE_OPEN : S_PLAY;
                                r_respawn <= 1'b1;
                            end
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.lvl       = r_lvl;
    assign bus.next_lvl  = r_next_lvl;
    assign bus.gate      = r_gate;
    assign bus.respawn   = r_respawn;
    assign bus.lives     = r_lives;
    assign bus.game_over = r_game_over;
    assign bus.win       = r_win;
    assign bus.state_dbg = r_state;

endmodule

// File: tb/tb_level_sequencer.sv
// Bench for level_sequencer: directed game scenarios followed by random play, every
// cycle compared against a game-rule model kept in terms of lives, landings left and frames left.
module tb_level_sequencer;

    localparam int NUM_LEVELS = 2;
    localparam int LANDINGS   = 5;
    localparam int START_LV   = 3;
    localparam int DONE_FR    = 60;
    localparam int DEATH_FR   = 45;

    logic clk = 1'b0;
    logic resetN;
    logic t_sof, t_sk, t_lr, t_hs, t_fo, t_og;

    int n_checks = 0;
    int n_fail   = 0;

    // model: phase uses the documented state numbers; counters count down what is left
    int m_phase, m_lvl, m_lives, m_land_left, m_wait;
    bit m_gate, m_load_pulse, m_resp_pulse;

    level_sequencer_if bus ();

    assign bus.startOfFrame = t_sof;
    assign bus.start_key    = t_sk;
    assign bus.land_regu    = t_lr;
    assign bus.hit_spike    = t_hs;
    assign bus.fell_out     = t_fo;
    assign bus.on_gate_tile = t_og;

    level_sequencer #(
        .NUM_LEVELS(NUM_LEVELS), .LANDINGS_TO_OPEN(LANDINGS), .START_LIVES(START_LV),
        .DONE_FRAMES(DONE_FR), .DEATH_FRAMES(DEATH_FR)
    ) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic begin_level(input int l);
        m_phase      = 1;
        m_lvl        = l;
        m_load_pulse = 1;
        m_resp_pulse = 1;
    endtask

    task automatic model_edge();
        bit died;
        m_load_pulse = 0;
        m_resp_pulse = 0;
        if (!resetN) begin
            m_phase = 0; m_lvl = 0; m_lives = START_LV; m_gate = 0;
            m_land_left = LANDINGS; m_wait = 0;
            return;
        end
        died = (t_hs || t_fo) && (m_lives > 0);
        if (m_phase == 0 || m_phase == 6 || m_phase == 7) begin
            if (t_sk) begin
                begin_level(0);
                m_lives = START_LV;
                m_gate  = 0;
            end
        end else if (m_phase == 1) begin
            m_phase = 2; m_land_left = LANDINGS; m_gate = 0;
        end else if ((m_phase == 2 || m_phase == 3) && died) begin
            m_phase = 5; m_wait = DEATH_FR; m_lives = m_lives - 1;
        end else if (m_phase == 2) begin
            if (t_lr && m_land_left > 0) begin
                m_land_left--;
                if (m_land_left == 0) begin m_phase = 3; m_gate = 1; end
            end
        end else if (m_phase == 3) begin
            if (t_og) begin m_phase = 4; m_wait = DONE_FR; end
        end else if (m_phase == 4) begin
            if (t_sof) begin
                m_wait--;
                if (m_wait == 0) begin
                    if (m_lvl == NUM_LEVELS - 1) m_phase = 7;
                    else begin_level(m_lvl + 1);
                end
            end
        end else if (m_phase == 5) begin
            if (t_sof) begin
                m_wait--;
                if (m_wait == 0) begin
                    if (m_lives == 0) m_phase = 6;
                    else begin
                        m_resp_pulse = 1;
                        m_phase = m_gate ? 3 : 2;
                    end
                end
            end
        end
    endtask

    task automatic compare_model();
        check_eq("state_dbg", bus.state_dbg, m_phase);
        check_eq("lvl",       bus.lvl,       m_lvl);
        check_eq("next_lvl",  bus.next_lvl,  m_load_pulse);
        check_eq("gate",      bus.gate,      m_gate);
        check_eq("respawn",   bus.respawn,   m_resp_pulse);
        check_eq("lives",     bus.lives,     m_lives);
        check_eq("game_over", bus.game_over, m_phase == 6);
        check_eq("win",       bus.win,       m_phase == 7);
    endtask

    // one clock: DUT and model see the same inputs, then one-cycle pulse inputs drop
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_model();
        t_sof = 0; t_lr = 0; t_hs = 0; t_fo = 0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin t_sof = 1; step(); end
    endtask

    task automatic lands(input int n);
        for (int i = 0; i < n; i++) begin t_lr = 1; step(); end
    endtask

    task automatic clear_level(input int hold);
        lands(LANDINGS);
        t_og = 1; step(); t_og = 0;
        frames(hold);
    endtask

    initial begin
        resetN = 0; t_sof = 0; t_sk = 0; t_lr = 0; t_hs = 0; t_fo = 0; t_og = 0;
        step();
        check_eq("rst_state", bus.state_dbg, 0);
        check_eq("rst_lives", bus.lives, 3);
        check_eq("rst_pulses", {bus.next_lvl, bus.respawn, bus.gate}, 0);
        resetN = 1;
        step();

        // start: one-cycle load at level 0
        t_sk = 1; step(); t_sk = 0;
        check_eq("start_next_lvl", bus.next_lvl, 1);
        check_eq("start_respawn", bus.respawn, 1);
        check_eq("start_lvl", bus.lvl, 0);
        step();
        check_eq("load_next_lvl_off", bus.next_lvl, 0);
        check_eq("play_state", bus.state_dbg, 2);
        check_eq("play_lives", bus.lives, 3);

        // gate opens on the fifth landing
        lands(4);
        check_eq("gate_after4", bus.gate, 0);
        lands(1);
        check_eq("gate_after5", bus.gate, 1);
        check_eq("gate_state", bus.state_dbg, 3);

        // level 0 cleared: 59 frames hold, 60th reloads at level 1
        t_og = 1; step(); t_og = 0;
        check_eq("lvl_done_state", bus.state_dbg, 4);
        frames(DONE_FR - 1);
        check_eq("lvl_done_hold", bus.state_dbg, 4);
        frames(1);
        check_eq("reload_lvl", bus.lvl, 1);
        check_eq("reload_next_lvl", bus.next_lvl, 1);
        step();
        check_eq("reload_next_lvl_off", bus.next_lvl, 0);

        // death beats a landing in the same cycle; landings survive the death
        lands(4);
        t_hs = 1; t_lr = 1; step();
        check_eq("death_lives", bus.lives, 2);
        check_eq("death_gate", bus.gate, 0);
        check_eq("death_state", bus.state_dbg, 5);
        frames(DEATH_FR - 1);
        check_eq("dying_no_respawn", bus.respawn, 0);
        frames(1);
        check_eq("respawn_pulse", bus.respawn, 1);
        check_eq("respawn_state", bus.state_dbg, 2);
        step();
        check_eq("respawn_off", bus.respawn, 0);
        lands(1);
        check_eq("kept_landings_gate", bus.gate, 1);

        // last level cleared: win, no reload
        t_og = 1; step(); t_og = 0;
        frames(DONE_FR);
        check_eq("win", bus.win, 1);
        check_eq("win_next_lvl", bus.next_lvl, 0);
        t_lr = 1; t_hs = 1; step();
        check_eq("win_sticky", bus.state_dbg, 7);

        // restart and lose all three lives
        t_sk = 1; step(); t_sk = 0;
        check_eq("restart_lvl", bus.lvl, 0);
        check_eq("restart_lives", bus.lives, 3);
        check_eq("restart_state", bus.state_dbg, 1);
        step();
        for (int d = 0; d < 3; d++) begin
            if (d == 1) t_fo = 1; else t_hs = 1;
            step();
            frames(DEATH_FR);
        end
        check_eq("game_over", bus.game_over, 1);
        check_eq("game_over_lives", bus.lives, 0);
        check_eq("game_over_no_respawn", bus.respawn, 0);
        t_hs = 1; step();
        check_eq("game_over_lives_hold", bus.lives, 0);
        t_sk = 1; step(); t_sk = 0;
        check_eq("go_restart_state", bus.state_dbg, 1);
        check_eq("go_restart_lives", bus.lives, 3);
        check_eq("go_restart_flag", bus.game_over, 0);

        // reset while holding LVL_DONE on level 1
        step();
        clear_level(DONE_FR);
        step();
        clear_level(10);
        check_eq("pre_reset_state", bus.state_dbg, 4);
        check_eq("pre_reset_lvl", bus.lvl, 1);
        resetN = 0; step(); resetN = 1;
        check_eq("mid_reset_state", bus.state_dbg, 0);
        check_eq("mid_reset_lvl", bus.lvl, 0);
        check_eq("mid_reset_gate", bus.gate, 0);
        check_eq("mid_reset_pulses", {bus.next_lvl, bus.respawn}, 0);

        // random play
        for (int c = 0; c < 20000; c++) begin
            t_sof  = ($urandom_range(0, 1) == 0);
            t_lr   = ($urandom_range(0, 3) == 0);
            t_hs   = ($urandom_range(0, 59) == 0);
            t_fo   = ($urandom_range(0, 89) == 0);
            t_og   = ($urandom_range(0, 5) == 0);
            t_sk   = ($urandom_range(0, 29) == 0);
            resetN = ($urandom_range(0, 2999) != 0);
            step();
        end
        resetN = 1; t_sk = 0; t_og = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
